// File: rtl/exec_ctrl_pkg.sv
// Shared constants for the exec_ctrl sequencer: ALU opcodes, EXT subops,
// instruction field positions and the controller state encoding.
package exec_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int INSN_W = 16;

  // ALU opcodes carried in the op field; EXT selects the non-ALU group.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_LD  = 3'd6;
  localparam logic [2:0] OP_EXT = 3'd7;

  // EXT subops; SUB_NOP doubles as SKZ when the zero flag is built in.
  localparam logic [1:0] SUB_ST   = 2'd0;
  localparam logic [1:0] SUB_CLC  = 2'd1;
  localparam logic [1:0] SUB_NOP  = 2'd2;
  localparam logic [1:0] SUB_HALT = 2'd3;

  // Instruction field bit positions.
  localparam int F_OP_HI  = 15;
  localparam int F_OP_LO  = 13;
  localparam int F_I      = 12;
  localparam int F_CE     = 11;
  localparam int F_SUB_HI = 12;
  localparam int F_SUB_LO = 11;
  localparam int F_IDX_LO = 8;
  localparam int F_IMM_HI = 7;
  localparam int F_IMM_LO = 0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  // Only the arithmetic ops consume and produce carry.
  function automatic logic op_uses_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Bus bundle between exec_ctrl and its environment: instruction fetch
// handshake plus the registered operand/result path to the ALU.
interface exec_ctrl_if
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W = 8
);
  logic [PC_W-1:0]   imem_addr;
  logic              imem_req;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_data;
  logic [2:0]        alu_code;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_r;
  logic              alu_ci;
  logic              alu_co;
  logic [DATA_W-1:0] alu_out;

  // Controller side.
  modport master (
    output imem_addr, imem_req, alu_code, alu_a, alu_r, alu_ci,
    input  imem_ack, imem_data, alu_co, alu_out
  );

  // Memory / ALU side.
  modport slave (
    input  imem_addr, imem_req, alu_code, alu_a, alu_r, alu_ci,
    output imem_ack, imem_data, alu_co, alu_out
  );
endinterface

// File: rtl/exec_regfile.sv
// Small register file: NREG x 8, one combinational read port, one
// synchronous write port, all entries cleared by synchronous reset.
module exec_regfile
  import exec_ctrl_pkg::*;
#(
  parameter  int NREG  = 8,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   w_we_vec;

  // One-hot write enable per entry.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_we
    assign w_we_vec[gi] = we && (waddr == IDX_W'(gi));
  end

  // Entry storage: clear on reset, otherwise take the write data when selected.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) begin
        r_mem[i] <= '0;
      end else if (w_we_vec[i]) begin
        r_mem[i] <= wdata;
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: fetch/decode/execute sequencer that feeds a combinational ALU
// and writes its result back into the accumulator and carry flag.
// Optional build macro ZERO_FLAG_EN adds a zero flag output and turns the
// EXT NOP subop into SKZ (skip next instruction when zero is set).
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  exec_ctrl_if.master       bus,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic [PC_W-1:0]   pc,
`ifdef ZERO_FLAG_EN
  output logic              zero,
`endif
  output logic              halted
);

  localparam int IDX_W = $clog2(NREG);

  state_t            r_state;
  state_t            w_state_next;
  logic [INSN_W-1:0] r_ir;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_acc;
  logic              r_carry;
  logic              r_req;
  logic [2:0]        r_alu_code;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_r;
  logic              r_alu_ci;
`ifdef ZERO_FLAG_EN
  logic              r_zero;
`endif

  logic [2:0]        w_op;
  logic [1:0]        w_sub;
  logic              w_use_imm;
  logic              w_carry_en;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_imm;
  logic              w_is_ext;
  logic              w_is_halt;
  logic              w_fetch_fire;
  logic              w_rf_we;
  logic [DATA_W-1:0] w_rf_rdata;

  // Instruction field decode from the held instruction register.
  assign w_op       = r_ir[F_OP_HI:F_OP_LO];
  assign w_sub      = r_ir[F_SUB_HI:F_SUB_LO];
  assign w_use_imm  = r_ir[F_I];
  assign w_carry_en = r_ir[F_CE];
  assign w_idx      = r_ir[F_IDX_LO +: IDX_W];
  assign w_imm      = r_ir[F_IMM_HI:F_IMM_LO];
  assign w_is_ext   = (w_op == OP_EXT);
  assign w_is_halt  = w_is_ext && (w_sub == SUB_HALT);

  // A fetch completes only when our own request is up; acks otherwise ignored.
  assign w_fetch_fire = (r_state == ST_FETCH) && r_req && bus.imem_ack;

  // ST commits in EXEC so the following DECODE already reads the new value.
  assign w_rf_we = (r_state == ST_EXEC) && w_is_ext && (w_sub == SUB_ST);

  exec_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (w_rf_we),
    .waddr (w_idx),
    .wdata (r_acc),
    .raddr (w_idx),
    .rdata (w_rf_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: FETCH waits for ack, HALT is terminal until reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FETCH:  if (w_fetch_fire) w_state_next = ST_DECODE;
      ST_DECODE: w_state_next = ST_EXEC;
      ST_EXEC:   w_state_next = w_is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:   w_state_next = ST_HALT;
      default:   w_state_next = ST_FETCH;
    endcase
  end

  // Datapath: fetch capture, operand staging for the ALU, and write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir       <= '0;
      r_pc       <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_req      <= 1'b0;
      r_alu_code <= '0;
      r_alu_a    <= '0;
      r_alu_r    <= '0;
      r_alu_ci   <= 1'b0;
`ifdef ZERO_FLAG_EN
      r_zero     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_fetch_fire) begin
            r_ir  <= bus.imem_data;
            r_pc  <= r_pc + PC_W'(1);
            r_req <= 1'b0;
          end else begin
            // First FETCH cycle after reset raises the request here.
            r_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_alu_code <= w_op;
          r_alu_a    <= r_acc;
          r_alu_r    <= w_use_imm ? w_imm : w_rf_rdata;
          r_alu_ci   <= w_carry_en && r_carry && op_uses_carry(w_op);
        end
        ST_EXEC: begin
          if (!w_is_ext) begin
            r_acc <= bus.alu_out;
            if (op_uses_carry(w_op)) begin
              r_carry <= bus.alu_co;
            end
`ifdef ZERO_FLAG_EN
            r_zero <= (bus.alu_out == '0);
`endif
          end else begin
            case (w_sub)
              SUB_CLC: r_carry <= 1'b0;
`ifdef ZERO_FLAG_EN
              SUB_NOP: if (r_zero) r_pc <= r_pc + PC_W'(1);
`endif
              default: ;
            endcase
          end
          // Request the next instruction straight away unless halting.
          r_req <= !w_is_halt;
        end
        default: r_req <= 1'b0;
      endcase
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.imem_req  = r_req;
  assign bus.alu_code  = r_alu_code;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_r     = r_alu_r;
  assign bus.alu_ci    = r_alu_ci;

  assign acc    = r_acc;
  assign carry  = r_carry;
  assign pc     = r_pc;
  assign halted = (r_state == ST_HALT);
`ifdef ZERO_FLAG_EN
  assign zero   = r_zero;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Testbench for exec_ctrl: instruction memory responder with random ack
// delays, a behavioural ALU, an instruction-level reference model and a
// scoreboard monitor that checks each completed instruction.
module tb_exec_ctrl;

  localparam int PC_W = 8;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_ctrl_if #(.PC_W(PC_W)) bus ();

  logic [7:0]      acc;
  logic            carry;
  logic [PC_W-1:0] pc;
  logic            halted;
`ifdef ZERO_FLAG_EN
  logic            zero;
`endif

  exec_ctrl #(
    .PC_W (PC_W),
    .NREG (NREG)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .acc    (acc),
    .carry  (carry),
    .pc     (pc),
`ifdef ZERO_FLAG_EN
    .zero   (zero),
`endif
    .halted (halted)
  );

  // Behavioural ALU: SUB carry-out is the borrow.
  always_comb begin
    bus.alu_co  = 1'b0;
    bus.alu_out = 8'h00;
    case (bus.alu_code)
      3'd0: {bus.alu_co, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_r} + {8'h00, bus.alu_ci};
      3'd1: {bus.alu_co, bus.alu_out} = {1'b0, bus.alu_a} - {1'b0, bus.alu_r} - {8'h00, bus.alu_ci};
      3'd2: bus.alu_out = bus.alu_a & bus.alu_r;
      3'd3: bus.alu_out = bus.alu_a | bus.alu_r;
      3'd4: bus.alu_out = bus.alu_a ^ bus.alu_r;
      3'd5: bus.alu_out = ~bus.alu_a;
      3'd6: bus.alu_out = bus.alu_r;
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0]      acc;
    logic            carry;
    logic [PC_W-1:0] pc;
    logic [2:0]      code;
    logic [7:0]      a;
    logic [7:0]      r;
    logic            ci;
    logic            halted;
    logic            zero;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference machine state.
  logic [7:0]      m_acc;
  logic            m_carry;
  logic            m_zero;
  logic [PC_W-1:0] m_pc;
  logic [7:0]      m_rf [NREG];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_acc   = 8'h00;
    m_carry = 1'b0;
    m_zero  = 1'b0;
    m_pc    = '0;
    for (int i = 0; i < NREG; i++) m_rf[i] = 8'h00;
    exp_q.delete();
  endtask

  // Executes one instruction on the reference machine and queues its outcome.
  task automatic model_exec(input logic [15:0] w);
    exp_t       e;
    logic [2:0] op;
    logic [1:0] sub;
    logic [7:0] opnd;
    int         s;
    int         ci;
    op   = w[15:13];
    sub  = w[12:11];
    opnd = w[12] ? w[7:0] : m_rf[w[10:8]];
    ci   = (w[11] && m_carry && (op == 3'd0 || op == 3'd1)) ? 1 : 0;
    e.a      = m_acc;
    e.code   = op;
    e.r      = opnd;
    e.ci     = (ci != 0);
    e.halted = 1'b0;
    m_pc = m_pc + 1'b1;
    case (op)
      3'd0: begin s = int'(m_acc) + int'(opnd) + ci; m_carry = (s > 255); m_acc = s[7:0]; end
      3'd1: begin s = int'(m_acc) - int'(opnd) - ci; m_carry = (s < 0);   m_acc = s[7:0]; end
      3'd2: m_acc = m_acc & opnd;
      3'd3: m_acc = m_acc | opnd;
      3'd4: m_acc = m_acc ^ opnd;
      3'd5: m_acc = ~m_acc;
      3'd6: m_acc = opnd;
      default: begin
        case (sub)
          2'd0: m_rf[w[10:8]] = m_acc;
          2'd1: m_carry = 1'b0;
`ifdef ZERO_FLAG_EN
          2'd2: if (m_zero) m_pc = m_pc + 1'b1;
`endif
          2'd3: e.halted = 1'b1;
          default: ;
        endcase
      end
    endcase
    if (op != 3'd7) m_zero = (m_acc == 8'h00);
    e.acc   = m_acc;
    e.carry = m_carry;
    e.pc    = m_pc;
    e.zero  = m_zero;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: an instruction has retired when the request rises
  // again or the controller enters HALT. The first request after reset has
  // no instruction behind it.
  logic mon_prev_req  = 1'b0;
  logic mon_prev_halt = 1'b0;
  logic mon_skip      = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_prev_req  = 1'b0;
      mon_prev_halt = 1'b0;
      mon_skip      = 1'b1;
    end else begin
      if ((bus.imem_req && !mon_prev_req) || (halted && !mon_prev_halt)) begin
        if (mon_skip) begin
          mon_skip = 1'b0;
        end else if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          $display("txn pc=%02h code=%0d a=%02h r=%02h ci=%0b -> acc=%02h carry=%0b halted=%0b",
                   pc, bus.alu_code, bus.alu_a, bus.alu_r, bus.alu_ci, acc, carry, halted);
          chk("acc",      32'(acc),          32'(e.acc));
          chk("carry",    32'(carry),        32'(e.carry));
          chk("pc",       32'(pc),           32'(e.pc));
          chk("alu_code", 32'(bus.alu_code), 32'(e.code));
          chk("alu_a",    32'(bus.alu_a),    32'(e.a));
          chk("alu_r",    32'(bus.alu_r),    32'(e.r));
          chk("alu_ci",   32'(bus.alu_ci),   32'(e.ci));
          chk("halted",   32'(halted),       32'(e.halted));
`ifdef ZERO_FLAG_EN
          chk("zero",     32'(zero),         32'(e.zero));
`endif
        end
      end
      mon_prev_req  = bus.imem_req;
      mon_prev_halt = halted;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Serve one instruction: wait for the request (bounded), stall dly cycles,
  // then ack. Random acks while the request is low must be ignored.
  task automatic serve(input logic [15:0] w, input int dly);
    int n;
    n = 0;
    while (!bus.imem_req && n < 100) begin
      bus.imem_ack  = 1'($urandom_range(0, 1));
      bus.imem_data = 16'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    bus.imem_ack = 1'b0;
    if (!bus.imem_req) begin
      total++;
      bad++;
      $display("FAIL req_timeout: imem_req still 0 after %0d cycles, expected 1", n);
      return;
    end
    chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
    for (int k = 0; k < dly; k++) begin
      @(posedge clk);
      #1;
      chk("req_hold",  32'(bus.imem_req),  32'd1);
      chk("addr_hold", 32'(bus.imem_addr), 32'(m_pc));
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = w;
    @(posedge clk);
    #1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'($urandom);
    model_exec(w);
  endtask

  // Let the accepted instruction run through DECODE and EXEC.
  task automatic wait_done();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    rst = 1'b1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    do_reset();
    chk("rst_acc",      32'(acc),          32'd0);
    chk("rst_carry",    32'(carry),        32'd0);
    chk("rst_pc",       32'(pc),           32'd0);
    chk("rst_req",      32'(bus.imem_req), 32'd0);
    chk("rst_halted",   32'(halted),       32'd0);
    chk("rst_alu_code", 32'(bus.alu_code), 32'd0);
    chk("rst_alu_a",    32'(bus.alu_a),    32'd0);
    chk("rst_alu_r",    32'(bus.alu_r),    32'd0);
    chk("rst_alu_ci",   32'(bus.alu_ci),   32'd0);

    // LD #F0; ADD #20; ADD CE #00
    serve(16'hD0F0, 0);
    serve(16'h1020, 1);
    wait_done();
    chk("p1_acc2",   32'(acc),   32'h10);
    chk("p1_carry2", 32'(carry), 32'd1);
    serve(16'h1800, 0);
    wait_done();
    chk("p1_acc3",   32'(acc),   32'h11);
    chk("p1_carry3", 32'(carry), 32'd0);

    // LD #05; SUB #07; AND #0F
    serve(16'hD005, 0);
    serve(16'h3007, 2);
    wait_done();
    chk("p2_sub_acc",   32'(acc),   32'hFE);
    chk("p2_sub_carry", 32'(carry), 32'd1);
    serve(16'h500F, 0);
    wait_done();
    chk("p2_and_acc",   32'(acc),   32'h0E);
    chk("p2_and_carry", 32'(carry), 32'd1);

    // LD #5A; ST r3; LD #00; OR r3; CLC
    serve(16'hD05A, 0);
    serve(16'hE300, 0);
    serve(16'hD000, 1);
    serve(16'h6300, 0);
    wait_done();
    chk("p3_or_acc", 32'(acc),     32'h5A);
    chk("p3_or_r",   32'(bus.alu_r), 32'h5A);
    serve(16'hE800, 0);
    wait_done();
    chk("p3_clc_carry", 32'(carry), 32'd0);

    // First fetch acked after 3 wait cycles.
    do_reset();
    serve(16'hF000, 3);
    chk("dly_pc", 32'(pc), 32'd1);
    wait_done();

    // Reset in a FETCH wait cycle, ack arriving one cycle late.
    serve(16'hD077, 0);
    wait_done();
    @(posedge clk);
    #1;
    chk("mid_req_before", 32'(bus.imem_req), 32'd1);
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hD0FF;
    chk("mid_req", 32'(bus.imem_req), 32'd0);
    chk("mid_pc",  32'(pc),           32'd0);
    chk("mid_acc", 32'(acc),          32'd0);
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    chk("late_ack_pc",  32'(pc),           32'd0);
    chk("late_ack_req", 32'(bus.imem_req), 32'd1);
    chk("late_ack_acc", 32'(acc),          32'd0);

    // Random program; long enough for the fetch address to wrap.
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b11111) w[11] = 1'b0;
      serve(w, $urandom_range(0, 2));
    end

    // HALT is terminal: no requests, no state movement.
    serve(16'hF800, 0);
    wait_done();
    chk("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("halt_req",  32'(bus.imem_req), 32'd0);
      chk("halt_pc",   32'(pc),           32'(m_pc));
      chk("halt_stay", 32'(halted),       32'd1);
    end
    bus.imem_ack = 1'b0;

    do_reset();
    chk("restart_pc",     32'(pc),     32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    serve(16'hF000, 0);
    wait_done();
    chk("restart_pc1", 32'(pc), 32'd1);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
